instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Instruction-fetch initiator that drives the instruction memory's address port and consumes its instruction output.
- Owns the program counter (PC) and the IF/ID pipeline register, and handles stalls, flushes and branch/jump redirects.
- Detects the halt instruction and reports fetch faults.
- The instruction memory is asynchronous-read: word 0 sits at byte address 0x4, and byte address A maps to word (A-4)>>2.

Parameters:
- RESET_PC, 32'h0000_0004, PC value loaded on reset (first instruction-memory word).
- MEM_SIZE, 32'h0800, instruction-memory size in bytes; the legal fetch window is [RESET_PC, RESET_PC+MEM_SIZE-4].
- HALT_WORD, 32'h0000_000C, instruction encoding that halts fetch (syscall).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold PC and IF/ID this cycle.
- flush  input  1  replace the IF/ID contents with a bubble this cycle.
- redirect  input  1  load PC from redirect_target.
- redirect_target  input  32  branch/jump target byte address.
- imem_address  output  32  address to instruction memory; combinationally equal to PC.
- imem_instruction  input  32  instruction word returned the same cycle.
- if_pc  output  32  PC of the instruction held in IF/ID.
- if_pc_plus4  output  32  if_pc+4, modulo 2^32.
- if_instruction  output  32  instruction held in IF/ID.
- if_valid  output  1  IF/ID holds a real instruction.
- halted  output  1  fetch stopped by HALT_WORD.
- fault  output  1  fetch stopped by an error.
- fault_cause  output  2  01 = misaligned redirect target, 10 = PC outside the legal fetch window, 00 = none.

Behaviour:
- Reset (clock edge with reset=1):
  - PC <= RESET_PC; state <= RUN.
  - if_pc, if_pc_plus4 and if_instruction <= 0; if_valid, halted and fault <= 0; fault_cause <= 00.
  - Reset overrides every other input and is valid in any state, including mid-stall, HALT and FAULT.
- States are RUN, HALT and FAULT. HALT and FAULT are exited only by reset.
- RUN, per-cycle priority: redirect > window check > stall > normal. flush is applied independently.
  - redirect=1, redirect_target[1:0]!=0:
    - state <= FAULT, fault_cause <= 01, PC unchanged.
    - IF/ID <= bubble (if_valid=0, if_instruction=0; if_pc and if_pc_plus4 hold).
  - redirect=1, target aligned:
    - PC <= redirect_target; IF/ID <= bubble, even if stall=1.
    - The instruction currently on imem_instruction is discarded, including a HALT_WORD.
    - An out-of-window target is caught on the following cycle by the window check.
  - No redirect, PC outside the legal window:
    - state <= FAULT, fault_cause <= 10, IF/ID <= bubble.
    - PC wrap-around from 32'hFFFF_FFFC to 0 therefore ends in FAULT rather than fetching.
  - stall=1: PC and IF/ID hold. If flush=1 in the same cycle, IF/ID <= bubble and PC still holds.
  - Normal cycle:
    - PC <= PC+4.
    - if_pc <= PC; if_pc_plus4 <= PC+4; if_instruction <= imem_instruction; if_valid <= 1.
    - If flush=1, IF/ID <= bubble instead, and PC still advances.
  - Normal capture with imem_instruction==HALT_WORD and flush=0:
    - The halt word enters IF/ID with if_valid=1; state <= HALT; PC holds.
- HALT:
  - halted=1 from the cycle after capture.
  - Next edge: IF/ID <= bubble; it stays a bubble thereafter.
  - PC frozen; redirect, stall and flush ignored.
- FAULT:
  - fault=1 and fault_cause are registered together with the transition.
  - PC frozen; IF/ID stays a bubble; all inputs except reset ignored.
- All register updates occur on the rising clock edge. imem_address has zero latency from PC.
- Fetch-to-IF/ID latency is 1 cycle.

Test Plan:
- Reset, release, memory words 0x11,0x22,0x33 at addresses 4,8,0xC -> imem_address 4,8,0xC on successive cycles; if_instruction 0x11,0x22,0x33 with if_pc 4,8,0xC and if_valid=1 starting one cycle after reset release.
- stall held 2 cycles at PC=8 -> imem_address stays 8 and IF/ID holds {pc 4, 0x11}; resumes with 0x22. stall+flush -> if_valid=0 and PC held at 8.
- redirect to 0x40 while PC=0xC with stall=1 -> next cycle imem_address=0x40 and if_valid=0; the cycle after, if_pc=0x40.
- redirect to 0x42 -> fault=1, fault_cause=01, if_valid=0; PC frozen until reset, and reset returns imem_address to 4.
- HALT_WORD (0x0000000C) at address 0x10 -> IF/ID holds it valid with if_pc=0x10, halted=1 one cycle later, then a bubble; imem_address frozen at 0x10; a subsequent redirect is ignored.
- Run sequentially to 0x804 with no halt -> fault=1, fault_cause=10 on the edge after PC reaches 0x804; no valid instruction is captured from 0x804.

Source files
------------

// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Instruction-fetch stage. Owns the program counter and the IF/ID pipeline
// register. It drives the asynchronous-read instruction memory and captures
// the returned word one cycle later. It also handles stalls, flushes and
// branch/jump redirects, stops on the halt instruction, and stops with a
// fault cause when a redirect target is misaligned or the PC leaves the
// legal fetch window.
//
// Ports:
//   clock             rising-edge clock
//   reset             synchronous, active-high reset
//   stall             hold PC and IF/ID this cycle
//   flush             replace IF/ID with a bubble this cycle
//   redirect          load PC from redirect_target
//   redirect_target   branch/jump target byte address
//   imem_address      instruction-memory address (combinationally the PC)
//   imem_instruction  instruction word returned in the same cycle
//   if_pc             PC of the instruction held in IF/ID
//   if_pc_plus4       if_pc + 4 (mod 2^32)
//   if_instruction    instruction held in IF/ID
//   if_valid          IF/ID holds a real instruction
//   halted            fetch stopped by HALT_WORD
//   fault             fetch stopped by an error
//   fault_cause       01 misaligned redirect, 10 PC out of window, 00 none
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0004,
  parameter logic [31:0] MEM_SIZE  = 32'h0000_0800,
  parameter logic [31:0] HALT_WORD = 32'h0000_000C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_instruction,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic [31:0] if_instruction,
  output logic        if_valid,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam logic [31:0] LAST_PC = RESET_PC + MEM_SIZE - 32'd4;

  localparam logic [1:0] CAUSE_NONE      = 2'b00;
  localparam logic [1:0] CAUSE_MISALIGN  = 2'b01;
  localparam logic [1:0] CAUSE_OUTWINDOW = 2'b10;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_HALT,
    ST_FAULT
  } state_t;

  state_t      stateQ;
  logic [31:0] pcQ;
  logic [31:0] ifPcQ;
  logic [31:0] ifPcPlus4Q;
  logic [31:0] ifInstrQ;
  logic        ifValidQ;
  logic        haltedQ;
  logic        faultQ;
  logic [1:0]  faultCauseQ;

  logic [31:0] pcPlus4;
  logic        pcInWindow;
  logic        targetAligned;

  // PC+4 wraps naturally at 2^32; a wrapped PC of 0 lands below the window
  // and is then caught by the window check instead of being fetched.
  assign pcPlus4       = pcQ + 32'd4;
  assign pcInWindow    = (pcQ >= RESET_PC) && (pcQ <= LAST_PC);
  assign targetAligned = (redirect_target[1:0] == 2'b00);

  // Single state machine: redirect beats the window check, which beats
  // stall, which beats a normal fetch. A halt word is captured into IF/ID
  // as a valid instruction while the PC stays put on it. HALT and FAULT
  // keep IF/ID as a bubble and ignore everything except reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      stateQ      <= ST_RUN;
      pcQ         <= RESET_PC;
      ifPcQ       <= '0;
      ifPcPlus4Q  <= '0;
      ifInstrQ    <= '0;
      ifValidQ    <= 1'b0;
      haltedQ     <= 1'b0;
      faultQ      <= 1'b0;
      faultCauseQ <= CAUSE_NONE;
    end else begin
      case (stateQ)
        ST_RUN: begin
          if (redirect) begin
            // The word currently returned by memory is dropped, halt or not.
            ifValidQ <= 1'b0;
            ifInstrQ <= '0;
            if (!targetAligned) begin
              stateQ      <= ST_FAULT;
              faultQ      <= 1'b1;
              faultCauseQ <= CAUSE_MISALIGN;
            end else begin
              pcQ <= redirect_target;
            end
          end else if (!pcInWindow) begin
            stateQ      <= ST_FAULT;
            faultQ      <= 1'b1;
            faultCauseQ <= CAUSE_OUTWINDOW;
            ifValidQ    <= 1'b0;
            ifInstrQ    <= '0;
          end else if (stall) begin
            if (flush) begin
              ifValidQ <= 1'b0;
              ifInstrQ <= '0;
            end
          end else if (flush) begin
            pcQ      <= pcPlus4;
            ifValidQ <= 1'b0;
            ifInstrQ <= '0;
          end else begin
            ifPcQ      <= pcQ;
            ifPcPlus4Q <= pcPlus4;
            ifInstrQ   <= imem_instruction;
            ifValidQ   <= 1'b1;
            if (imem_instruction == HALT_WORD) begin
              stateQ  <= ST_HALT;
              haltedQ <= 1'b1;
            end else begin
              pcQ <= pcPlus4;
            end
          end
        end
        ST_HALT: begin
          ifValidQ <= 1'b0;
          ifInstrQ <= '0;
        end
        default: begin
          ifValidQ <= 1'b0;
          ifInstrQ <= '0;
        end
      endcase
    end
  end

  assign imem_address   = pcQ;
  assign if_pc          = ifPcQ;
  assign if_pc_plus4    = ifPcPlus4Q;
  assign if_instruction = ifInstrQ;
  assign if_valid       = ifValidQ;
  assign halted         = haltedQ;
  assign fault          = faultQ;
  assign fault_cause    = faultCauseQ;

endmodule
